// File: rtl/serial_add_sub_pkg.sv
// Shared types and constants for the bit-serial adder/subtractor.
package serial_add_sub_pkg;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   localparam logic OP_ADD = 1'b1;
   localparam logic OP_SUB = 1'b0;

endpackage

// File: rtl/serial_add_sub_if.sv
// Request/result bundle between a client and serial_add_sub.
interface serial_add_sub_if #(parameter int WIDTH = 8);

   logic             start;
   logic             a_ns;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] s;
   logic             cout;
   logic             ovf;

   modport master (output start, a_ns, a, b, input busy, done, s, cout, ovf);
   modport slave  (input start, a_ns, a, b, output busy, done, s, cout, ovf);

endinterface

// File: rtl/fas.sv
// One-bit full adder/subtractor; b is inverted when a_ns=0 (subtract).
module fas (
   input  logic a,
   input  logic b,
   input  logic cin,
   input  logic a_ns,
   output logic s,
   output logic cout
);

   logic bx;

   assign bx   = b ^ ~a_ns;
   assign s    = a ^ bx ^ cin;
   assign cout = (a & bx) | (cin & (a ^ bx));

endmodule

// File: rtl/serial_add_sub.sv
// Bit-serial WIDTH-bit add/subtract: one fas stage plus a carry flop, LSB first.
module serial_add_sub
   import serial_add_sub_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input logic             clk,
   input logic             rst_n,
   serial_add_sub_if.slave bus
);

   localparam int CW = $clog2(WIDTH);

   state_t           state, state_n;
   logic [WIDTH-1:0] a_sr, b_sr, s_q;
   logic [WIDTH-2:0] r_sr;
   logic [WIDTH-1:0] r_next;
   logic [CW-1:0]    cnt;
   logic             op_q, carry_q, cout_q, ovf_q;
   logic             f_s, f_cout;
   logic             load, step, last;

   fas u_fas (
      .a    (a_sr[0]),
      .b    (b_sr[0]),
      .cin  (carry_q),
      .a_ns (op_q),
      .s    (f_s),
      .cout (f_cout)
   );

   assign last   = (cnt == CW'(WIDTH - 1));
   assign r_next = {f_s, r_sr};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_n;
   end

   always_comb begin
      state_n = state;
      load    = 1'b0;
      step    = 1'b0;
      case (state)
         IDLE: if (bus.start) begin
            load    = 1'b1;
            state_n = RUN;
         end
         RUN: begin
            step = 1'b1;
            if (last) state_n = DONE;
         end
         DONE:    state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_sr    <= '0;
         b_sr    <= '0;
         r_sr    <= '0;
         s_q     <= '0;
         cnt     <= '0;
         op_q    <= 1'b0;
         carry_q <= 1'b0;
         cout_q  <= 1'b0;
         ovf_q   <= 1'b0;
      end else if (load) begin
         a_sr    <= bus.a;
         b_sr    <= bus.b;
         op_q    <= bus.a_ns;
         // subtract is a + ~b + 1: the +1 enters as the initial carry
         carry_q <= (bus.a_ns == OP_SUB);
         cnt     <= '0;
      end else if (step) begin
         a_sr    <= a_sr >> 1;
         b_sr    <= b_sr >> 1;
         r_sr    <= r_next[WIDTH-1:1];
         carry_q <= f_cout;
         if (last) begin
            // results become visible only here, so s is stable through RUN
            s_q    <= r_next;
            cout_q <= f_cout;
            ovf_q  <= carry_q ^ f_cout;
         end else begin
            cnt <= cnt + CW'(1);
         end
      end
   end

   assign bus.busy = (state != IDLE);
   assign bus.done = (state == DONE);
   assign bus.s    = s_q;
   assign bus.cout = cout_q;
   assign bus.ovf  = ovf_q;

endmodule

// File: tb/tb_serial_add_sub.sv
// Directed + random + exhaustive checks of serial_add_sub against an arithmetic model.
module tb_serial_add_sub;
   import serial_add_sub_pkg::*;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   serial_add_sub_if #(.WIDTH(8)) b8 ();
   serial_add_sub_if #(.WIDTH(4)) b4 ();

   serial_add_sub #(.WIDTH(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(b8.slave));
   serial_add_sub #(.WIDTH(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(b4.slave));

   int checks = 0;
   int errors = 0;
   logic [7:0] last_s8 = 8'h00;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reference: plain unsigned/signed arithmetic on integers
   task automatic ref_op(input int w, input logic op, input int x, input int y,
                         output int rs, output int rc, output int rv);
      int m, xs, ys, r;
      m  = (1 << w) - 1;
      xs = (x >= (1 << (w - 1))) ? x - (1 << w) : x;
      ys = (y >= (1 << (w - 1))) ? y - (1 << w) : y;
      r  = (op == OP_ADD) ? xs + ys : xs - ys;
      rs = ((op == OP_ADD) ? x + y : x - y) & m;
      rc = (op == OP_ADD) ? int'(x + y > m) : int'(x >= y);
      rv = int'(r < -(1 << (w - 1)) || r > (1 << (w - 1)) - 1);
   endtask

   task automatic op8(input logic op, input logic [7:0] x, input logic [7:0] y, input string tag);
      int es, ec, ev, k;
      ref_op(8, op, int'(x), int'(y), es, ec, ev);
      @(negedge clk);
      b8.start = 1'b1; b8.a_ns = op; b8.a = x; b8.b = y;
      @(posedge clk);
      @(negedge clk);
      b8.start = 1'b0;
      check({tag, ":busy"}, 32'(b8.busy), 32'd1);
      check({tag, ":s_hold"}, 32'(b8.s), 32'(last_s8));
      // k counts edges after the start edge; done must appear after edge WIDTH
      k = 0;
      while (!b8.done && k < 20) begin
         @(posedge clk);
         k++;
         @(negedge clk);
      end
      check({tag, ":latency"}, 32'(k), 32'd8);
      check({tag, ":s"}, 32'(b8.s), 32'(es));
      check({tag, ":cout"}, 32'(b8.cout), 32'(ec));
      check({tag, ":ovf"}, 32'(b8.ovf), 32'(ev));
      @(negedge clk);
      check({tag, ":done_width"}, 32'(b8.done), 32'd0);
      check({tag, ":busy_fall"}, 32'(b8.busy), 32'd0);
      check({tag, ":s_after"}, 32'(b8.s), 32'(es));
      last_s8 = 8'(es);
   endtask

   task automatic op4(input logic op, input logic [3:0] x, input logic [3:0] y);
      int es, ec, ev, k;
      ref_op(4, op, int'(x), int'(y), es, ec, ev);
      @(negedge clk);
      b4.start = 1'b1; b4.a_ns = op; b4.a = x; b4.b = y;
      @(posedge clk);
      @(negedge clk);
      b4.start = 1'b0;
      k = 0;
      while (!b4.done && k < 12) begin
         @(posedge clk);
         k++;
         @(negedge clk);
      end
      check("w4:latency", 32'(k), 32'd4);
      check("w4:s", 32'(b4.s), 32'(es));
      check("w4:cout", 32'(b4.cout), 32'(ec));
      check("w4:ovf", 32'(b4.ovf), 32'(ev));
   endtask

   initial begin
      int k, ndone;
      logic [7:0] s_at_done;
      b8.start = 1'b0; b8.a_ns = 1'b0; b8.a = '0; b8.b = '0;
      b4.start = 1'b0; b4.a_ns = 1'b0; b4.a = '0; b4.b = '0;

      repeat (2) @(negedge clk);
      check("rst:busy", 32'(b8.busy), 32'd0);
      check("rst:done", 32'(b8.done), 32'd0);
      check("rst:s", 32'(b8.s), 32'd0);
      check("rst:cout", 32'(b8.cout), 32'd0);
      check("rst:ovf", 32'(b8.ovf), 32'd0);
      check("rst:s4", 32'(b4.s), 32'd0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      check("idle:busy", 32'(b8.busy), 32'd0);

      op8(OP_ADD, 8'h05, 8'h03, "add_05_03");
      op8(OP_ADD, 8'h7F, 8'h01, "add_7f_01");
      op8(OP_ADD, 8'hFF, 8'h01, "add_ff_01");
      op8(OP_SUB, 8'h03, 8'h05, "sub_03_05");
      op8(OP_SUB, 8'h80, 8'h01, "sub_80_01");

      // start presented mid-RUN must be ignored
      @(negedge clk);
      b8.start = 1'b1; b8.a_ns = OP_ADD; b8.a = 8'h10; b8.b = 8'h20;
      @(posedge clk);
      @(negedge clk);
      b8.start = 1'b0;
      repeat (3) @(negedge clk);
      b8.start = 1'b1; b8.a_ns = OP_SUB; b8.a = 8'hAA; b8.b = 8'h55;
      @(negedge clk);
      b8.start = 1'b0;
      ndone = 0;
      s_at_done = 8'h00;
      for (int i = 0; i < 24; i++) begin
         @(negedge clk);
         if (b8.done) begin
            ndone++;
            s_at_done = b8.s;
         end
      end
      check("ign:done_count", 32'(ndone), 32'd1);
      check("ign:s", 32'(s_at_done), 32'h30);
      last_s8 = 8'h30;
      op8(OP_SUB, 8'hAA, 8'h55, "ign:after");

      // leave nonzero outputs, then abort an operation with reset
      op8(OP_SUB, 8'h80, 8'h01, "pre_rst");
      @(negedge clk);
      b8.start = 1'b1; b8.a_ns = OP_ADD; b8.a = 8'h0F; b8.b = 8'h01;
      @(posedge clk);
      @(negedge clk);
      b8.start = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("abort:busy", 32'(b8.busy), 32'd0);
      check("abort:s", 32'(b8.s), 32'd0);
      check("abort:cout", 32'(b8.cout), 32'd0);
      check("abort:ovf", 32'(b8.ovf), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      ndone = 0;
      for (int i = 0; i < 14; i++) begin
         @(negedge clk);
         if (b8.done) ndone++;
      end
      check("abort:no_done", 32'(ndone), 32'd0);
      last_s8 = 8'h00;
      op8(OP_ADD, 8'h0F, 8'h01, "abort:retry");

      for (int i = 0; i < 30; i++) begin
         k = int'($urandom_range(0, 1));
         op8(k[0], 8'($urandom), 8'($urandom), "rand");
      end

      for (int op = 0; op < 2; op++)
         for (int x = 0; x < 16; x++)
            for (int y = 0; y < 16; y++)
               op4(op[0], 4'(x), 4'(y));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
